// File: rtl/frame_pixel_streamer_pkg.sv
// Shared types and constants for the raster pixel streamer.
// The ST1_* values mirror the stage-1 CNN core frame defaults.
package frame_pixel_streamer_pkg;

  localparam int unsigned ST1_IX         = 28;
  localparam int unsigned ST1_IY         = 28;
  localparam int unsigned ST1_I_F_BW     = 8;
  localparam int unsigned TAG_FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_GAP   = 2'd2,
    ST_DRAIN = 2'd3
  } stream_state_e;

  typedef struct packed {
    logic frame_last;
    logic line_last;
  } pix_tag_t;

  // Pointer advance for the 3-entry ring (no power-of-two wrap available)
  function automatic logic [1:0] ptr_next(input logic [1:0] ptr);
    return (ptr == 2'(TAG_FIFO_DEPTH - 1)) ? 2'd0 : ptr + 2'd1;
  endfunction

endpackage

// File: rtl/frame_pixel_streamer_fifo.sv
// Three-entry synchronous FIFO carrying {tags, pixel} with an occupancy count.
module stream_tag_fifo
  import frame_pixel_streamer_pkg::*;
#(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic [1:0]   count
);

  logic [W-1:0] mem [TAG_FIFO_DEPTH];
  logic [1:0]   wr_ptr;
  logic [1:0]   rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'(TAG_FIFO_DEPTH)) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TAG_FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_pixel_streamer.sv
// Reads one IX x IY frame from a 1-cycle-latency memory and streams it
// in raster order over valid/ready with row- and frame-end tags.
module frame_pixel_streamer
  import frame_pixel_streamer_pkg::*;
#(
  parameter int unsigned IX       = ST1_IX,
  parameter int unsigned IY       = ST1_IY,
  parameter int unsigned BW       = ST1_I_F_BW,
  parameter int unsigned AW       = $clog2(IX * IY),
  parameter int unsigned LINE_GAP = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_start,
  input  logic [AW-1:0] i_base_addr,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_mem_rd_en,
  output logic [AW-1:0] o_mem_addr,
  input  logic [BW-1:0] i_mem_rdata,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [BW-1:0] o_out_pixel,
  output logic          o_line_last,
  output logic          o_frame_last
);

  localparam int unsigned XW = (IX > 1) ? $clog2(IX) : 1;
  localparam int unsigned YW = (IY > 1) ? $clog2(IY) : 1;
  localparam int unsigned GW = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;
  localparam int unsigned FW = BW + 2;

  stream_state_e state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [GW-1:0] gap_cnt;
  logic [AW-1:0] addr;
  logic          busy;
  logic          done;

  logic          inflight;
  pix_tag_t      inflight_tag;

  logic [1:0]    fifo_count;
  logic [FW-1:0] fifo_wdata;
  logic [FW-1:0] fifo_rdata;
  logic          fifo_pop;
  pix_tag_t      head_tag;

  logic          issue;
  logic          row_end;
  logic          frame_end;

  // Credit check: buffered plus in-flight pixels never exceed FIFO depth
  assign issue     = (state == ST_RUN) &&
                     (({1'b0, fifo_count} + {2'b00, inflight}) < 3'(TAG_FIFO_DEPTH));
  assign row_end   = (x == XW'(IX - 1));
  assign frame_end = row_end && (y == YW'(IY - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      gap_cnt <= '0;
      addr    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            addr  <= i_base_addr;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b1;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr <= addr + AW'(1);
            if (row_end) begin
              x <= '0;
              y <= y + YW'(1);
              if (frame_end) begin
                state <= ST_DRAIN;
              end else if (LINE_GAP > 0) begin
                gap_cnt <= '0;
                state   <= ST_GAP;
              end
            end else begin
              x <= x + XW'(1);
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GW'(LINE_GAP - 1)) begin
            state <= ST_RUN;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        ST_DRAIN: begin
          if ((fifo_count == 2'd0) && !inflight) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tag travels alongside the read so it lands with the returned pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inflight     <= 1'b0;
      inflight_tag <= '0;
    end else begin
      inflight                <= issue;
      inflight_tag.frame_last <= frame_end;
      inflight_tag.line_last  <= row_end;
    end
  end

  assign fifo_wdata = {inflight_tag, i_mem_rdata};
  assign fifo_pop   = o_out_valid && i_out_ready;

  stream_tag_fifo #(
    .W (FW)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (inflight),
    .wdata   (fifo_wdata),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .count   (fifo_count)
  );

  assign head_tag     = fifo_rdata[FW-1:BW];
  assign o_out_valid  = (fifo_count != 2'd0);
  assign o_out_pixel  = o_out_valid ? fifo_rdata[BW-1:0] : '0;
  assign o_line_last  = o_out_valid && head_tag.line_last;
  assign o_frame_last = o_out_valid && head_tag.frame_last;

  assign o_mem_rd_en  = issue;
  assign o_mem_addr   = addr;
  assign o_busy       = busy;
  assign o_done       = done;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer: 4x3 frame, 8-bit pixels, mem[a] = a.
module tb_frame_pixel_streamer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: LINE_GAP = 0
  logic       a_start = 1'b0;
  logic [7:0] a_base  = 8'd0;
  logic       a_busy, a_done, a_rd, a_valid, a_ll, a_fl;
  logic [7:0] a_addr, a_pix;
  logic [7:0] a_rdata = 8'd0;
  logic       a_ready = 1'b1;

  // Instance b: LINE_GAP = 2
  logic       b_start = 1'b0;
  logic [7:0] b_base  = 8'd0;
  logic       b_busy, b_done, b_rd, b_valid, b_ll, b_fl;
  logic [7:0] b_addr, b_pix;
  logic [7:0] b_rdata = 8'd0;
  logic       b_ready = 1'b1;

  frame_pixel_streamer #(.IX(4), .IY(3), .BW(8), .AW(8), .LINE_GAP(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_start(a_start), .i_base_addr(a_base),
    .o_busy(a_busy), .o_done(a_done), .o_mem_rd_en(a_rd), .o_mem_addr(a_addr),
    .i_mem_rdata(a_rdata), .o_out_valid(a_valid), .i_out_ready(a_ready),
    .o_out_pixel(a_pix), .o_line_last(a_ll), .o_frame_last(a_fl)
  );

  frame_pixel_streamer #(.IX(4), .IY(3), .BW(8), .AW(8), .LINE_GAP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .i_start(b_start), .i_base_addr(b_base),
    .o_busy(b_busy), .o_done(b_done), .o_mem_rd_en(b_rd), .o_mem_addr(b_addr),
    .i_mem_rdata(b_rdata), .o_out_valid(b_valid), .i_out_ready(b_ready),
    .o_out_pixel(b_pix), .o_line_last(b_ll), .o_frame_last(b_fl)
  );

  // Image memories: 1-cycle read latency, contents equal the address
  always @(posedge clk) begin
    if (a_rd) a_rdata <= a_addr;
    if (b_rd) b_rdata <= b_addr;
  end

  typedef struct {
    logic [7:0] pix;
    logic       ll;
    logic       fl;
    int         cyc;
  } hs_t;

  hs_t        qa[$];
  hs_t        qb[$];
  logic [7:0] aqa[$];
  int cyc  = 0;
  int a_dn = 0;
  int b_dn = 0;

  // Handshake, address and done-pulse monitor
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_valid && a_ready) qa.push_back('{pix: a_pix, ll: a_ll, fl: a_fl, cyc: cyc});
    if (b_valid && b_ready) qb.push_back('{pix: b_pix, ll: b_ll, fl: b_fl, cyc: cyc});
    if (a_rd) aqa.push_back(a_addr);
    if (a_done) a_dn <= a_dn + 1;
    if (b_done) b_dn <= b_dn + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] outs_a();
    return {a_busy, a_done, a_rd, a_addr, a_valid, a_pix, a_ll, a_fl};
  endfunction

  function automatic logic [21:0] outs_b();
    return {b_busy, b_done, b_rd, b_addr, b_valid, b_pix, b_ll, b_fl};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] base);
    @(negedge clk);
    a_base  = base;
    a_start = 1'b1;
    @(posedge clk);
    #1 a_start = 1'b0;
  endtask

  task automatic start_b(input logic [7:0] base);
    @(negedge clk);
    b_base  = base;
    b_start = 1'b1;
    @(posedge clk);
    #1 b_start = 1'b0;
  endtask

  task automatic wait_done_a(input int limit, input string name, input bit rnd);
    int n = 0;
    while (!a_done && n < limit) begin
      if (rnd) a_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check({name, "_done_seen"}, int'(a_done), 1);
    a_ready = 1'b1;
  endtask

  task automatic wait_done_b(input int limit, input string name);
    int n = 0;
    while (!b_done && n < limit) begin
      step();
      n++;
    end
    check({name, "_done_seen"}, int'(b_done), 1);
  endtask

  // Checks 12 handshakes starting at index s: pixel = base+k, tags by position
  task automatic frame_check(input bit inst_b, input int s, input int base, input string name);
    int n;
    int errs = 0;
    hs_t h;
    n = inst_b ? qb.size() : qa.size();
    check({name, "_count"}, n - s, 12);
    for (int k = 0; k < 12 && s + k < n; k++) begin
      h = inst_b ? qb[s + k] : qa[s + k];
      if (h.pix !== 8'(base + k) || h.ll !== ((k % 4) == 3) || h.fl !== (k == 11)) errs++;
    end
    check({name, "_order_tags"}, errs, 0);
  endtask

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic       done;
    logic       rd;
    logic [7:0] addr;
    logic       valid;
    logic [7:0] pix;
    logic       ll;
    logic       fl;
  } vec_t;

  vec_t tbl [17];

  initial begin
    int s, d, n, errs, want;
    logic [21:0] exp_o;

    // Cycle-by-cycle expectations for a base-0 frame, ready held high;
    // entry c is sampled just after the c-th edge following start acceptance
    for (int c = 0; c < 17; c++) begin
      tbl[c].ready = 1'b1;
      tbl[c].busy  = (c <= 14);
      tbl[c].done  = (c == 15);
      tbl[c].rd    = (c <= 11);
      tbl[c].addr  = 8'((c <= 12) ? c : 12);
      tbl[c].valid = (c >= 2) && (c <= 13);
      tbl[c].pix   = tbl[c].valid ? 8'(c - 2) : 8'd0;
      tbl[c].ll    = tbl[c].valid && (((c - 2) % 4) == 3);
      tbl[c].fl    = (c == 13);
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs_a", int'(outs_a()), 0);
    check("reset_outs_b", int'(outs_b()), 0);
    @(negedge clk) reset_n = 1'b1;
    repeat (2) step();

    // Basic frame via the vector table
    s = qa.size();
    d = a_dn;
    start_a(8'd0);
    for (int c = 0; c < 17; c++) begin
      if (c > 0) step();
      exp_o = {tbl[c].busy, tbl[c].done, tbl[c].rd, tbl[c].addr,
               tbl[c].valid, tbl[c].pix, tbl[c].ll, tbl[c].fl};
      check($sformatf("basic_c%0d", c), int'(outs_a()), int'(exp_o));
      a_ready = tbl[c].ready;
    end
    frame_check(1'b0, s, 0, "basic");
    errs = 0;
    for (int k = 1; k < 12 && s + k < qa.size(); k++)
      if (qa[s + k].cyc - qa[s + k - 1].cyc != 1) errs++;
    check("basic_no_bubbles", errs, 0);
    check("basic_done_pulses", a_dn - d, 1);

    // Row gap on the LINE_GAP=2 instance
    s = qb.size();
    d = b_dn;
    start_b(8'd0);
    wait_done_b(80, "gap");
    step();
    frame_check(1'b1, s, 0, "gap");
    errs = 0;
    if (qb.size() >= s + 12) begin
      for (int k = 1; k < 12; k++) begin
        want = (k == 4 || k == 8) ? 3 : 1;
        if (qb[s + k].cyc - qb[s + k - 1].cyc != want) errs++;
      end
    end else begin
      errs = 99;
    end
    check("gap_spacing", errs, 0);
    check("gap_done_pulses", b_dn - d, 1);

    // Backpressure: stall 5 cycles while pixel 2 is at the head
    s = qa.size();
    start_a(8'd0);
    n = 0;
    while (!(a_valid && a_pix == 8'd2) && n < 20) begin
      step();
      n++;
    end
    check("bp_reach_pix2", int'({a_valid, a_pix}), int'({1'b1, 8'd2}));
    a_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("bp_hold%0d", i), int'({a_valid, a_pix, a_ll, a_fl}),
            int'({1'b1, 8'd2, 1'b0, 1'b0}));
    end
    check("bp_rd_stopped", int'(a_rd), 0);
    a_ready = 1'b1;
    wait_done_a(80, "bp", 1'b0);
    step();
    frame_check(1'b0, s, 0, "bp");

    // Random ready
    s = qa.size();
    start_a(8'd0);
    wait_done_a(400, "rand", 1'b1);
    step();
    frame_check(1'b0, s, 0, "rand");

    // Base offset 100 and wrapping base 254
    for (int t = 0; t < 2; t++) begin
      int base;
      base = (t == 0) ? 100 : 254;
      s = qa.size();
      n = aqa.size();
      start_a(8'(base));
      wait_done_a(80, $sformatf("base%0d", base), 1'b0);
      step();
      frame_check(1'b0, s, base, $sformatf("base%0d", base));
      errs = 0;
      if (aqa.size() != n + 12) errs = 99;
      else for (int k = 0; k < 12; k++) if (aqa[n + k] !== 8'(base + k)) errs++;
      check($sformatf("base%0d_addrs", base), errs, 0);
    end

    // Start pulsed mid-frame is ignored
    s = qa.size();
    d = a_dn;
    start_a(8'd0);
    repeat (5) step();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    wait_done_a(80, "busy_start", 1'b0);
    repeat (20) step();
    check("busy_start_pixels", qa.size() - s, 12);
    check("busy_start_done_pulses", a_dn - d, 1);
    check("busy_start_idle", int'(a_busy), 0);

    // Start asserted in the done cycle is accepted
    start_a(8'd0);
    wait_done_a(80, "done_cycle_first", 1'b0);
    s = qa.size();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    check("done_cycle_start_busy", int'({a_busy, a_done}), int'({1'b1, 1'b0}));
    wait_done_a(80, "done_cycle_second", 1'b0);
    step();
    frame_check(1'b0, s, 0, "done_cycle");

    // Asynchronous reset mid-frame, then a clean restart
    s = qa.size();
    start_a(8'd0);
    n = 0;
    while (qa.size() < s + 6 && n < 30) begin
      step();
      n++;
    end
    check("rst_reach_pix5", qa.size() - s, 6);
    reset_n = 1'b0;
    #1;
    check("rst_async_outs_a", int'(outs_a()), 0);
    check("rst_async_outs_b", int'(outs_b()), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step();
    s = qa.size();
    start_a(8'd0);
    step();
    check("rst_restart_c1_invalid", int'(a_valid), 0);
    step();
    check("rst_restart_first", int'({a_valid, a_pix, a_ll, a_fl}),
          int'({1'b1, 8'd0, 1'b0, 1'b0}));
    wait_done_a(80, "rst_restart", 1'b0);
    step();
    frame_check(1'b0, s, 0, "rst_restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
